// File: rtl/hash_core_param.sv
// Parametrised sequential byte-absorbing hash core driving an external 8-bit S-box.
// Optional macro HASH_CORE_CNT_SAT_EN makes the length counter saturate instead of wrapping.
module hash_core_param #(
  parameter int               N_H       = 8,
  parameter int               CNT_BYTES = 8,
  parameter logic [8*N_H-1:0] IV        = 64'hA0CC84CC3A1FA311
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               msg_valid,
  input  logic [7:0]         msg_byte,
  input  logic               msg_last,
  input  logic               finish,
  output logic               msg_ready,
  output logic [7:0]         sbox_in,
  input  logic [7:0]         sbox_out,
  output logic [8*N_H-1:0]   digest,
  output logic               digest_valid,
  output logic               busy
);

  localparam int IW    = (N_H > 2) ? $clog2(N_H) : 1;
  localparam int CW    = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;
  localparam int CBITS = 8 * CNT_BYTES;
  localparam logic [IW-1:0] LAST_I  = IW'(N_H - 1);
  localparam logic [CW-1:0] LAST_CI = CW'(CNT_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [N_H-1:0][7:0]   r_h;
  logic [CBITS-1:0]      r_c;
  logic [7:0]            r_m;
  logic                  r_last;
  logic [IW-1:0]         r_i;
  logic [CW-1:0]         r_ci;

  logic                  w_step_last;
  logic [IW-1:0]         w_inext;
  logic [2:0]            w_ramt;
  logic [7:0]            w_cbyte;
  logic [7:0]            w_key;
  logic [7:0]            w_mix;
  logic [7:0]            w_rotated;
  logic [CBITS-1:0]      w_cinc;

  assign w_step_last = (r_i == LAST_I);
  assign w_inext     = w_step_last ? '0 : r_i + 1'b1;

  if (IW >= 3) begin : g_ramt
    assign w_ramt = r_i[2:0];
  end else begin : g_ramt
    assign w_ramt = 3'(r_i);
  end

  always_comb begin
    w_cbyte = '0;
    for (int k = 0; k < CNT_BYTES; k++) begin
      if (CW'(k) == r_ci) w_cbyte = r_c[8*k +: 8];
    end
  end

  // The neighbour byte is read from the live state, so the final step sees the freshly written H[0].
  assign w_key     = (r_state == S_FINAL) ? w_cbyte : r_m;
  assign w_mix     = r_h[w_inext] ^ w_key;
  assign w_rotated = (w_mix << w_ramt) | (w_mix >> (4'd8 - {1'b0, w_ramt}));

`ifdef HASH_CORE_CNT_SAT_EN
  assign w_cinc = (&r_c) ? r_c : r_c + 1'b1;
`else
  assign w_cinc = r_c + 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_ABSORB;
    end else begin
      case (r_state)
        S_ABSORB: begin
          if (msg_valid)   w_next = S_ROUND;
          else if (finish) w_next = S_FINAL;
        end
        S_ROUND: if (w_step_last) w_next = r_last ? S_FINAL : S_ABSORB;
        S_FINAL: if (w_step_last) w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    msg_ready    = (r_state == S_ABSORB);
    busy         = (r_state == S_ROUND) || (r_state == S_FINAL);
    digest_valid = (r_state == S_DONE);
    sbox_in      = busy ? w_rotated : 8'h00;
  end

  // Start outranks every state so an in-flight pass can be abandoned at any step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h    <= IV;
      r_c    <= '0;
      r_m    <= '0;
      r_last <= 1'b0;
      r_i    <= '0;
      r_ci   <= '0;
    end else if (start) begin
      r_h    <= IV;
      r_c    <= '0;
      r_last <= 1'b0;
      r_i    <= '0;
      r_ci   <= '0;
    end else begin
      case (r_state)
        S_ABSORB: begin
          if (msg_valid) begin
            r_m    <= msg_byte;
            r_c    <= w_cinc;
            r_last <= msg_last | finish;
            r_i    <= '0;
            r_ci   <= '0;
          end else if (finish) begin
            r_i  <= '0;
            r_ci <= '0;
          end
        end
        S_ROUND: begin
          r_h[r_i] <= sbox_out;
          r_i      <= w_inext;
        end
        S_FINAL: begin
          r_h[r_i] <= sbox_out;
          r_i      <= w_inext;
          r_ci     <= (r_ci == LAST_CI) ? '0 : r_ci + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign digest = r_h;

endmodule

// File: tb/tb_hash_core_param.sv
// Self-checking bench for hash_core_param: a default instance and a CNT_BYTES=1 instance
// are driven in lockstep and compared against a byte-level reference model.
module tb_hash_core_param;

  localparam int          NH   = 8;
  localparam logic [63:0] IV_C = 64'hA0CC84CC3A1FA311;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        msg_valid;
  logic [7:0]  msg_byte;
  logic        msg_last;
  logic        finish;

  logic        rdyA, rdyB, dvA, dvB, busyA, busyB;
  logic [7:0]  sinA, sinB, soutA, soutB;
  logic [63:0] digA, digB;

  int          sboxMode;
  int          checks;
  int          errors;
  int          cycNow;
  int          dvLatency;
  logic [7:0]  msgBuf [256];
  int          acc [256];
  logic [7:0]  capKeyA, capKeyB;

  typedef struct packed {
    logic [3:0]  len;
    logic [31:0] data;
    logic [1:0]  mode;
    logic [63:0] expA;
    logic [63:0] expB;
  } vec_t;

  vec_t vecs [5];

  assign soutA = (sboxMode != 0) ? 8'(sinA * 8'd167 + 8'd13) : sinA;
  assign soutB = (sboxMode != 0) ? 8'(sinB * 8'd167 + 8'd13) : sinB;

  hash_core_param dutA (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_valid(msg_valid),
    .msg_byte(msg_byte), .msg_last(msg_last), .finish(finish),
    .msg_ready(rdyA), .sbox_in(sinA), .sbox_out(soutA), .digest(digA),
    .digest_valid(dvA), .busy(busyA)
  );

  hash_core_param #(.N_H(8), .CNT_BYTES(1), .IV(IV_C)) dutB (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_valid(msg_valid),
    .msg_byte(msg_byte), .msg_last(msg_last), .finish(finish),
    .msg_ready(rdyB), .sbox_in(sinB), .sbox_out(soutB), .digest(digB),
    .digest_valid(dvB), .busy(busyB)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycNow++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
    return 8'((x << r) | (x >> (8 - r)));
  endfunction

  function automatic logic [7:0] sboxF(input logic [7:0] x);
    return (sboxMode != 0) ? 8'(x * 167 + 13) : x;
  endfunction

  // Reference: absorb every byte, then a pass keyed by the length counter bytes.
  function automatic logic [63:0] modelHash(input int len, input int cntBytes);
    logic [7:0]  h [8];
    logic [63:0] c, mask, ivv, res;
    logic [7:0]  key;
    ivv  = IV_C;
    mask = (cntBytes >= 8) ? {64{1'b1}} : ((64'd1 << (8 * cntBytes)) - 64'd1);
    for (int k = 0; k < NH; k++) h[k] = ivv[8*k +: 8];
    c = 64'd0;
    for (int n = 0; n < len; n++) begin
`ifdef HASH_CORE_CNT_SAT_EN
      if (c != mask) c = c + 64'd1;
`else
      c = (c + 64'd1) & mask;
`endif
      for (int i = 0; i < NH; i++) h[i] = sboxF(rotl8(h[(i + 1) % NH] ^ msgBuf[n], i % 8));
    end
    for (int i = 0; i < NH; i++) begin
      key  = 8'(c >> (8 * (i % cntBytes)));
      h[i] = sboxF(rotl8(h[(i + 1) % NH] ^ key, i % 8));
    end
    res = 64'd0;
    for (int k = 0; k < NH; k++) res[8*k +: 8] = h[k];
    return res;
  endfunction

  task automatic loadBuf(input logic [31:0] d, input int len);
    for (int k = 0; k < len; k++) msgBuf[k] = d[8*k +: 8];
  endtask

  // mode 0: msg_last on final byte, 1: separate finish, 2: finish together with final byte.
  task automatic applyStimulus(input int len, input int mode, input bit gaps);
    int   bound;
    int   finOffset;
    int   cyc;
    logic rdy;
    bit   accepted;
    start = 1'b1;
    tick();
    start = 1'b0;
    finOffset = NH + 1;
    for (int n = 0; n < len; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      msg_valid = 1'b1;
      msg_byte  = msgBuf[n];
      msg_last  = (n == len - 1) && (mode == 0);
      finish    = (n == len - 1) && (mode == 2);
      accepted  = 1'b0;
      bound     = 0;
      while (!accepted && bound < 40) begin
        rdy = rdyA;
        tick();
        bound++;
        accepted = rdy;
      end
      acc[n]    = cycNow;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      finish    = 1'b0;
      checkOutput("byte_accepted", 64'(accepted), 64'd1);
    end
    if (len == 0 || mode == 1) begin
      bound = 0;
      while (!rdyA && bound < 40) begin
        tick();
        bound++;
      end
      finish = 1'b1;
      tick();
      finish    = 1'b0;
      finOffset = 1;
    end
    cyc       = 1;
    dvLatency = -1;
    while (cyc <= 40) begin
      if (cyc == finOffset) begin
        capKeyA = sinA ^ digA[15:8];
        capKeyB = sinB ^ digB[15:8];
      end
      if (dvA) begin
        dvLatency = cyc;
        break;
      end
      tick();
      cyc++;
    end
    checkOutput("dv_latency", 64'(dvLatency), 64'(finOffset + NH));
  endtask

  initial begin
    logic [7:0] seq [8];
    int         len, mode, bound;
    checks = 0; errors = 0; cycNow = 0; sboxMode = 1;
    reset_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_byte = 8'h00;
    msg_last = 1'b0; finish = 1'b0;

    vecs[0] = '{len: 4'd1, data: 32'h0000005A, mode: 2'd0, expA: 64'd0, expB: 64'd0};
    vecs[1] = '{len: 4'd2, data: 32'h00000201, mode: 2'd1, expA: 64'd0, expB: 64'd0};
    vecs[2] = '{len: 4'd3, data: 32'h008000FF, mode: 2'd2, expA: 64'd0, expB: 64'd0};
    vecs[3] = '{len: 4'd4, data: 32'hEFBEADDE, mode: 2'd0, expA: 64'd0, expB: 64'd0};
    vecs[4] = '{len: 4'd0, data: 32'h00000000, mode: 2'd1, expA: 64'd0, expB: 64'd0};
    for (int v = 0; v < 5; v++) begin
      loadBuf(vecs[v].data, int'(vecs[v].len));
      vecs[v].expA = modelHash(int'(vecs[v].len), 8);
      vecs[v].expB = modelHash(int'(vecs[v].len), 1);
    end

    #12;
    checkOutput("reset_ready", 64'(rdyA), 64'd0);
    checkOutput("reset_busy", 64'(busyA), 64'd0);
    checkOutput("reset_dv", 64'(dvA), 64'd0);
    checkOutput("reset_sbox_in", 64'(sinA), 64'd0);
    checkOutput("reset_digestA", digA, IV_C);
    checkOutput("reset_digestB", digB, IV_C);
    reset_n = 1'b1;
    tick();

    // Single zero byte through an identity S-box.
    sboxMode = 0;
    seq = '{8'hA3, 8'h3E, 8'hE8, 8'h66, 8'h48, 8'h99, 8'h28, 8'hD1};
    msgBuf[0] = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ready_after_start", 64'(rdyA), 64'd1);
    msg_valid = 1'b1; msg_byte = 8'h00; msg_last = 1'b1;
    tick();
    msg_valid = 1'b0; msg_last = 1'b0;
    for (int k = 0; k < NH; k++) begin
      checkOutput("round_sbox_in", 64'(sinA), 64'(seq[k]));
      checkOutput("round_busy", 64'(busyA), 64'd1);
      tick();
    end
    for (int n = NH + 1; n <= 2 * NH + 1; n++) begin
      checkOutput("single_dv_timing", 64'(dvA), 64'(n == 2 * NH + 1));
      if (n < 2 * NH + 1) tick();
    end
    checkOutput("single_digestA", digA, modelHash(1, 8));
    checkOutput("single_digestB", digB, modelHash(1, 1));

    // Zero-length message.
    sboxMode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checkOutput("zl_count", 64'(sinA ^ digA[15:8]), 64'd0);
    for (int n = 1; n <= NH + 1; n++) begin
      checkOutput("zl_ready", 64'(rdyA), 64'd0);
      checkOutput("zl_dv", 64'(dvA), 64'(n == NH + 1));
      if (n < NH + 1) tick();
    end
    checkOutput("zl_digestA", digA, modelHash(0, 8));
    checkOutput("zl_digestB", digB, modelHash(0, 1));

    // Backpressure: msg_valid held high across three bytes.
    msgBuf[0] = 8'h11; msgBuf[1] = 8'h22; msgBuf[2] = 8'h33;
    applyStimulus(3, 0, 1'b0);
    checkOutput("bp_interval1", 64'(acc[1] - acc[0]), 64'(NH + 1));
    checkOutput("bp_interval2", 64'(acc[2] - acc[1]), 64'(NH + 1));
    checkOutput("bp_countA", 64'(capKeyA), 64'd3);
    checkOutput("bp_countB", 64'(capKeyB), 64'd3);
    checkOutput("bp_digestA", digA, modelHash(3, 8));
    checkOutput("bp_digestB", digB, modelHash(3, 1));

    // Abort at round step 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    msg_valid = 1'b1; msg_byte = 8'h77;
    tick();
    msg_valid = 1'b0;
    repeat (4) tick();
    checkOutput("abort_busy_pre", 64'(busyA), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("abort_ready", 64'(rdyA), 64'd1);
    checkOutput("abort_busy", 64'(busyA), 64'd0);
    checkOutput("abort_digest", digA, IV_C);
    checkOutput("abort_sbox_in", 64'(sinA), 64'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checkOutput("abort_count", 64'(sinA ^ digA[15:8]), 64'd0);
    bound = 0;
    while (!dvA && bound < 40) begin
      tick();
      bound++;
    end
    checkOutput("abort_dv", 64'(dvA), 64'd1);
    checkOutput("abort_digestA", digA, modelHash(0, 8));

    // Asynchronous reset in the middle of FINAL.
    start = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (2) tick();
    checkOutput("ar_busy_pre", 64'(busyA), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("ar_ready", 64'(rdyA), 64'd0);
    checkOutput("ar_busy", 64'(busyA), 64'd0);
    checkOutput("ar_dv", 64'(dvA), 64'd0);
    checkOutput("ar_sbox_in", 64'(sinA), 64'd0);
    checkOutput("ar_digestA", digA, IV_C);
    checkOutput("ar_digestB", digB, IV_C);
    #2 reset_n = 1'b1;
    msg_valid = 1'b1; finish = 1'b1;
    repeat (2) tick();
    checkOutput("ar_idle_ready", 64'(rdyA), 64'd0);
    checkOutput("ar_idle_busy", 64'(busyA), 64'd0);
    checkOutput("ar_idle_dv", 64'(dvA), 64'd0);
    msg_valid = 1'b0; finish = 1'b0;
    msgBuf[0] = 8'h9A;
    applyStimulus(1, 0, 1'b0);
    checkOutput("ar_resume_digestA", digA, modelHash(1, 8));

    // Table-driven directed messages.
    for (int v = 0; v < 5; v++) begin
      loadBuf(vecs[v].data, int'(vecs[v].len));
      applyStimulus(int'(vecs[v].len), int'(vecs[v].mode), 1'b1);
      checkOutput("vec_digestA", digA, vecs[v].expA);
      checkOutput("vec_digestB", digB, vecs[v].expB);
    end

    // Randomized messages against the reference model.
    for (int r = 0; r < 6; r++) begin
      len  = $urandom_range(0, 6);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < len; k++) msgBuf[k] = 8'($urandom);
      applyStimulus(len, mode, 1'b1);
      checkOutput("rand_digestA", digA, modelHash(len, 8));
      checkOutput("rand_digestB", digB, modelHash(len, 1));
    end

    // 256 bytes: the one-byte counter wraps (or saturates) at FINAL entry.
    for (int k = 0; k < 256; k++) msgBuf[k] = 8'($urandom);
    applyStimulus(256, 0, 1'b0);
`ifdef HASH_CORE_CNT_SAT_EN
    checkOutput("cnt_boundaryB", 64'(capKeyB), 64'hFF);
`else
    checkOutput("cnt_boundaryB", 64'(capKeyB), 64'h00);
`endif
    checkOutput("cnt_boundaryA", 64'(capKeyA), 64'h00);
    checkOutput("cnt_digestA", digA, modelHash(256, 8));
    checkOutput("cnt_digestB", digB, modelHash(256, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_core_param.md
# hash_core_param

Parametrised sequential hash core. It holds an N_H-byte chaining state and a CNT_BYTES-byte message-length counter. It absorbs message bytes through a valid/ready handshake, then runs a finalization pass over the length counter and presents the digest. It sits between the byte-stream front end and the digest consumer, and drives an external combinational 8-bit S-box.

## Interface
Parameters:
- N_H, 8, number of state bytes H[0..N_H-1]; legal range 2..32.
- CNT_BYTES, 8, width of the length counter C in bytes; legal range 1..8.
- IV, 64'hA0CC84CC3A1FA311, flattened initial vector of width 8*N_H bits; H[k] = IV[8k+7:8k].

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new message: load IV, clear C.
- msg_valid  in  1  msg_byte is valid.
- msg_byte  in  8  message byte M.
- msg_last  in  1  qualifies msg_byte as the final byte.
- finish  in  1  end the message with no byte attached; this is how a zero-length message is hashed.
- msg_ready  out  1  core accepts a byte this cycle.
- sbox_in  out  8  S-box operand (combinational).
- sbox_out  in  8  S-box result, combinational from sbox_in.
- digest  out  8*N_H  current H, with H[0] in the LSBs.
- digest_valid  out  1  digest is final.
- busy  out  1  high in ROUND or FINAL.

## Operation
FSM states:
- IDLE
  - H=IV, C=0.
  - Goes to ABSORB on start.
- ABSORB
  - msg_ready=1.
  - On msg_valid: latch M, C <= C+1, latch last=msg_last, i <= 0, go to ROUND.
  - Otherwise, on finish: i <= 0, go to FINAL.
- ROUND
  - Runs for N_H cycles, i = 0..N_H-1.
  - Each cycle: sbox_in = rotl8(H[(i+1) mod N_H] ^ M, i mod 8), and H[i] <= sbox_out.
  - Updates are in place and sequential, so at i=N_H-1 the operand uses the already-updated H[0].
  - After i=N_H-1: go to FINAL if last is set, otherwise to ABSORB.
- FINAL
  - Runs for N_H cycles.
  - Same as ROUND, with M replaced by C_byte[i mod CNT_BYTES]; C_byte[0] is the LSB of C.
  - C is frozen during FINAL.
  - After the last step, go to DONE.
- DONE
  - digest_valid=1, held until start.
  - msg_valid and finish are ignored.

Arithmetic and boundary rules:
- rotl8 by 0 is the identity.
- C counts accepted bytes modulo 2^(8*CNT_BYTES).
- msg_valid together with finish in ABSORB: the byte is accepted and treated as last.
- msg_valid or finish outside ABSORB: ignored; the producer must hold the byte until msg_ready.
- start has priority in every state, including mid-ROUND and mid-FINAL. It aborts the current operation, loads IV, clears C and last, and the next state is ABSORB.
- sbox_in is don't-care (drive 0) outside ROUND and FINAL.

## Timing
Reset values:
- H=IV, C=0, state IDLE.
- msg_ready=0, digest_valid=0, busy=0, sbox_in=0, digest=IV.

Cycle-level timing:
- start sampled at edge t → msg_ready=1 from cycle t+1.
- A byte accepted at edge t → busy=1 for cycles t+1..t+N_H → msg_ready=1 again at t+N_H+1. Sustained throughput is 1 byte per N_H+1 cycles.
- Last byte accepted at t → FINAL at t+N_H+1..t+2N_H → digest_valid=1 from t+2N_H+1.
- finish at t → digest_valid=1 from t+N_H+1.
- digest reflects H every cycle; it is only meaningful while digest_valid=1.
- Reset assertion mid-operation returns every output to its reset value asynchronously.

## Configuration
- Macro HASH_CORE_CNT_SAT_EN.
- When defined: C saturates at all-ones; further bytes are still absorbed, but C no longer changes.
- When undefined: C wraps to 0 after all-ones.

## Test plan
- **Single byte, identity S-box:** N_H=8, default IV, start, byte 0x00 with msg_last.
  - Required sbox_in sequence in ROUND: A3,3E,E8,66,48,99,28,D1.
  - Then digest_valid exactly 2N_H+1=17 cycles after acceptance.
- **Zero-length message:** start, then finish with no byte.
  - FINAL runs with C=0.
  - digest_valid 9 cycles later.
  - msg_ready low from the finish edge onward.
- **Handshake under backpressure:** msg_valid held high for 3 bytes.
  - msg_ready pulses once every 9 cycles.
  - C=3 at FINAL entry.
  - No byte is lost or duplicated.
- **Abort mid-ROUND:** start asserted at i=4.
  - Next cycle: state ABSORB, digest=IV, C=0, busy=0.
- **Counter boundary:** CNT_BYTES=1, 256 bytes absorbed.
  - Without the macro: C=0x00 at FINAL.
  - With HASH_CORE_CNT_SAT_EN: C=0xFF.
- **Asynchronous reset during FINAL:** assert reset_n=0 between edges.
  - All outputs take their reset values immediately.
  - digest=IV.
  - Operation resumes only after a new start.
